// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receiver with optional even parity, stop-bit check and FIFO write strobe
module uart_rx_deframer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 sample_tick,
  input  logic                 p_enbl,
  input  logic                 rxd,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] dout,
  output logic                 write_en,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_meta, rx_sync, par_en, perr;
  always_ff @(posedge clk) begin
    if (areset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en     <= 1'b0;
      perr       <= 1'b0;
      dout       <= '0;
      write_en   <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta  <= rxd;
      rx_sync  <= rx_meta;
      write_en <= 1'b0;
      overrun  <= 1'b0;
      if (sample_tick) begin
        tick_cnt <= tick_cnt + TW'(1);
        case (state)
          IDLE: if (!rx_sync) begin
            tick_cnt <= '0;
            par_en   <= p_enbl;
            busy     <= 1'b1;
            state    <= START;
          end
          START: if (tick_cnt == HALF) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= !rx_sync;
            state    <= rx_sync ? IDLE : DATA;
          end
          DATA: if (tick_cnt == LAST) begin
            tick_cnt <= '0;
            shreg    <= {rx_sync, shreg[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= par_en ? PARITY : STOP;
          end
          PARITY: if (tick_cnt == LAST) begin
            tick_cnt <= '0;
            perr     <= ^shreg ^ rx_sync;
            state    <= STOP;
          end
          STOP: if (tick_cnt == LAST) begin
            tick_cnt   <= '0;
            dout       <= shreg;
            parity_err <= par_en & perr;
            frame_err  <= !rx_sync;
            write_en   <= !fifo_full;
            overrun    <= fifo_full;
            busy       <= !rx_sync;
            state      <= rx_sync ? IDLE : WAIT_HIGH;
          end
          WAIT_HIGH: if (rx_sync) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: scoreboard bench driving directed UART frames at 64 clks per bit
module tb_uart_rx_deframer;
  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       p_enbl = 1'b0;
  logic       rxd = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] dout;
  logic       write_en, busy, parity_err, frame_err, overrun;
  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int ov_cnt = 0;
  uart_rx_deframer #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk),
    .areset(areset),
    .sample_tick(sample_tick),
    .p_enbl(p_enbl),
    .rxd(rxd),
    .fifo_full(fifo_full),
    .dout(dout),
    .write_en(write_en),
    .busy(busy),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun(overrun)
  );
  initial forever #5 clk = ~clk;
  initial forever begin
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end
  endtask
  task automatic bit_time();
    repeat (64) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic sbit);
    p_enbl = pen;
    rxd = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      bit_time();
    end
    if (pen) begin
      rxd = pbit;
      bit_time();
    end
    rxd = sbit;
    bit_time();
  endtask
  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, 32'(dout), 0);
    check({tag, "_write_en"}, 32'(write_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_parity_err"}, 32'(parity_err), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask
  always @(negedge clk) begin
    if (!areset && (write_en || overrun)) begin
      if (write_en) wr_cnt++;
      if (overrun) ov_cnt++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got dout=%0h write_en=%b overrun=%b, required no output", dout, write_en, overrun);
      end else begin
        e = q.pop_front();
        check("dout", 32'(dout), 32'(e.d));
        check("parity_err", 32'(parity_err), 32'(e.pe));
        check("frame_err", 32'(frame_err), 32'(e.fe));
        check("overrun", 32'(overrun), 32'(e.ov));
        check("write_en", 32'(write_en), 32'(!e.ov));
      end
    end
  end
  initial begin
    logic [7:0] frames [16];
    frames = '{8'h23, 8'h33, 8'h43, 8'h53, 8'h63, 8'h73, 8'h24, 8'h34,
               8'h44, 8'h54, 8'h64, 8'h74, 8'h41, 8'h61, 8'h00, 8'h70};
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    areset = 1'b0;
    repeat (20) @(negedge clk);
    q.push_back('{d: 8'h23, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'h23, 1'b0, 1'b0, 1'b1);
    check("busy_after_0x23", 32'(busy), 0);
    check("q_after_0x23", q.size(), 0);
    bit_time();
    q.push_back('{d: 8'h53, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'h53, 1'b1, 1'b0, 1'b1);
    q.push_back('{d: 8'h53, pe: 1'b1, fe: 1'b0, ov: 1'b0});
    send_frame(8'h53, 1'b1, 1'b1, 1'b1);
    check("q_after_parity", q.size(), 0);
    bit_time();
    q.push_back('{d: 8'h41, pe: 1'b0, fe: 1'b1, ov: 1'b0});
    send_frame(8'h41, 1'b0, 1'b0, 1'b0);
    repeat (3) bit_time();
    check("busy_wait_high", 32'(busy), 1);
    check("q_after_break", q.size(), 0);
    rxd = 1'b1;
    bit_time();
    check("busy_after_break", 32'(busy), 0);
    q.push_back('{d: 8'h61, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'h61, 1'b0, 1'b0, 1'b1);
    check("q_after_0x61", q.size(), 0);
    bit_time();
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    check("busy_glitch_start", 32'(busy), 1);
    repeat (40) @(negedge clk);
    check("busy_glitch_end", 32'(busy), 0);
    bit_time();
    fifo_full = 1'b1;
    q.push_back('{d: 8'h70, pe: 1'b0, fe: 1'b0, ov: 1'b1});
    send_frame(8'h70, 1'b0, 1'b0, 1'b1);
    fifo_full = 1'b0;
    check("q_after_overrun", q.size(), 0);
    bit_time();
    for (int i = 0; i < 16; i++) begin
      q.push_back('{d: frames[i], pe: 1'b0, fe: 1'b0, ov: 1'b0});
      send_frame(frames[i], 1'b1, ^frames[i], 1'b1);
    end
    check("q_after_burst", q.size(), 0);
    rxd = 1'b0;
    bit_time();
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("busy_mid_frame", 32'(busy), 1);
    areset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (3) @(negedge clk);
    areset = 1'b0;
    repeat (4) bit_time();
    check("busy_after_reset", 32'(busy), 0);
    check("write_count", wr_cnt, 21);
    check("overrun_count", ov_cnt, 1);
    check("q_final", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
UART receive deframer. Takes the serial line from the far-end transmitter and recovers 8-bit characters using 16x oversampling ticks from the baud generator. Checks optional even parity and the stop bit, then pushes each character into the receive FIFO through a one-cycle write strobe. Sits between the line input and the rx FIFO, mirroring the transmit path.

Parameters:
OVERSAMPLE, 16, sample_tick pulses per bit period; must be an even value of 4 or more.
DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
clk  input  1  system clock
areset  input  1  synchronous, active-high reset
sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
p_enbl  input  1  1 = frame carries an even-parity bit after the data bits
rxd  input  1  serial line, idle high, asynchronous to clk
fifo_full  input  1  rx FIFO full flag
dout  output  DATA_BITS  received character, held until the next frame completes
write_en  output  1  one-clk strobe that writes dout into the rx FIFO
busy  output  1  frame reception in progress
parity_err  output  1  parity mismatch on the last frame; held with dout
frame_err  output  1  stop bit sampled low on the last frame; held with dout
overrun  output  1  one-clk pulse: frame completed while fifo_full = 1, so the character was dropped

Behaviour:
- Reset and synchronisation
  - rxd passes through a 2-flop synchronizer; both flops reset to 1.
  - On areset (sampled at posedge clk) every output becomes 0 and the FSM goes to IDLE.
  - The reset takes effect mid-frame as well: the frame in progress is discarded and write_en does not assert.
- Counters
  - tick_cnt counts sample_tick pulses within a bit.
  - bit_cnt counts received data bits.
  - All state advances only on clk edges where sample_tick = 1, except the completion strobe.
- p_enbl is latched on entry to START and ignored for the rest of the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE
  - busy = 0.
  - When the synchronized rxd = 0 on a tick: clear tick_cnt, go to START.
- START
  - busy = 1.
  - At tick_cnt = OVERSAMPLE/2-1 (mid start bit), rxd is re-checked.
  - If rxd = 0: clear tick_cnt and bit_cnt, go to DATA.
  - If rxd = 1: false start; go to IDLE with no output.
- DATA
  - At tick_cnt = OVERSAMPLE-1, sample rxd into the shift register MSB and shift right, so LSB-first order is preserved. Clear tick_cnt.
  - After DATA_BITS samples, go to PARITY if the latched p_enbl = 1, otherwise go to STOP.
- PARITY
  - At tick_cnt = OVERSAMPLE-1, compute perr = (XOR of data bits) XOR rxd. This is even parity: the parity bit makes the total count of ones even.
  - Go to STOP.
- STOP
  - At tick_cnt = OVERSAMPLE-1, sample the stop bit.
  - On the next clk:
    - dout is loaded with the shift register.
    - parity_err is loaded with perr, or 0 if parity was disabled.
    - frame_err is loaded with the inverted stop sample.
    - If fifo_full = 0, write_en = 1 for exactly one clk.
    - If fifo_full = 1, write_en stays 0 and overrun = 1 for exactly one clk.
  - Next state: IDLE if the stop sample = 1, otherwise WAIT_HIGH.
- WAIT_HIGH
  - busy = 1.
  - Stay until the synchronized rxd = 1 on a tick, then go to IDLE. A break condition (line held low) therefore yields one errored frame, not a stream of them.
- Latency: write_en asserts 1 clk after the sample_tick at the stop-bit sample point.
- Erroneous frames are still written to the FIFO. parity_err and frame_err qualify them and stay valid until the next completion.
- A new start bit is accepted on the first tick after returning to IDLE, so back-to-back frames with a single stop bit are received.
- sample_tick is treated as 0 in any cycle where areset = 1.

Test Plan:
- Test conditions: OVERSAMPLE = 16, tick every 4 clks; the bench drives rxd at 64 clks per bit.
- Frame 0x23, p_enbl = 0, stop = 1 -> one write_en pulse, dout = 0x23, parity_err = 0, frame_err = 0, busy returns to 0.
- Frame 0x53 with p_enbl = 1 and parity bit 0 -> dout = 0x53, parity_err = 0. Same frame with parity bit 1 -> dout = 0x53, parity_err = 1, write_en still pulses.
- Frame 0x41 with stop bit driven 0, then line held low for 3 bit times -> exactly one write_en, frame_err = 1, FSM held in WAIT_HIGH until rxd rises. Next frame 0x61 is received cleanly.
- rxd low glitch lasting 3 ticks (shorter than half a bit) -> returns to IDLE, no write_en, busy drops within 8 ticks.
- fifo_full = 1 during frame 0x70 -> overrun pulses for 1 clk, no write_en, dout = 0x70.
- 16 back-to-back frames (0x23, 0x33, ..., 0x70) with parity on -> 16 write_en pulses in order, no errors. Then assert areset mid-data-bit of a 17th frame -> no write_en; all outputs 0 on the next clk.
